// File: rtl/trace_retire_serializer_pkg.sv
// Shared types and width constants for the retire-trace serializer.
// Holds the per-instruction trace record and default sizing.
package trace_retire_serializer_pkg;

    localparam int DEF_ENQ_PORTS = 2;
    localparam int DEF_DEPTH     = 8;
    localparam int ARCH_LEN      = 32;
    localparam int NUM_WARPS     = 8;
    localparam int WARP_ID_BITS  = $clog2(NUM_WARPS);
    localparam int NUM_LANES     = 16;
    localparam int REG_BITS      = 8;
    localparam int NUM_REGS      = 3;
    localparam int LANE_DATA_W   = NUM_LANES * ARCH_LEN;

    typedef struct packed {
        logic                   enable;
        logic [REG_BITS-1:0]    address;
        logic [LANE_DATA_W-1:0] data;
    } trace_reg_t;

    typedef struct packed {
        logic [ARCH_LEN-1:0]           pc;
        logic [WARP_ID_BITS-1:0]       warpId;
        logic [NUM_LANES-1:0]          tmask;
        trace_reg_t [NUM_REGS-1:0]     regs;
    } trace_inst_t;

    // Width needed to hold a count in 0..n.
    function automatic int cnt_width(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/trace_retire_serializer_if.sv
// Writeback-to-tracer bundle: per-port retire inputs, serialized
// trace outputs, and FIFO occupancy status.
interface trace_retire_serializer_if
    import trace_retire_serializer_pkg::*;
#(
    parameter int ENQ_PORTS = DEF_ENQ_PORTS,
    parameter int DEPTH     = DEF_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENQ_PORTS-1:0]              in_valid;
    logic                              in_ready;
    logic [ENQ_PORTS*ARCH_LEN-1:0]     in_pc;
    logic [ENQ_PORTS*WARP_ID_BITS-1:0] in_warpId;
    logic [ENQ_PORTS*NUM_LANES-1:0]    in_tmask;
    logic [ENQ_PORTS-1:0]              in_regs_0_enable;
    logic [ENQ_PORTS*REG_BITS-1:0]     in_regs_0_address;
    logic [ENQ_PORTS*LANE_DATA_W-1:0]  in_regs_0_data;
    logic [ENQ_PORTS-1:0]              in_regs_1_enable;
    logic [ENQ_PORTS*REG_BITS-1:0]     in_regs_1_address;
    logic [ENQ_PORTS*LANE_DATA_W-1:0]  in_regs_1_data;
    logic [ENQ_PORTS-1:0]              in_regs_2_enable;
    logic [ENQ_PORTS*REG_BITS-1:0]     in_regs_2_address;
    logic [ENQ_PORTS*LANE_DATA_W-1:0]  in_regs_2_data;

    logic                    inst_valid;
    logic [ARCH_LEN-1:0]     inst_pc;
    logic [WARP_ID_BITS-1:0] inst_warpId;
    logic [NUM_LANES-1:0]    inst_tmask;
    logic                    inst_regs_0_enable;
    logic [REG_BITS-1:0]     inst_regs_0_address;
    logic [LANE_DATA_W-1:0]  inst_regs_0_data;
    logic                    inst_regs_1_enable;
    logic [REG_BITS-1:0]     inst_regs_1_address;
    logic [LANE_DATA_W-1:0]  inst_regs_1_data;
    logic                    inst_regs_2_enable;
    logic [REG_BITS-1:0]     inst_regs_2_address;
    logic [LANE_DATA_W-1:0]  inst_regs_2_data;

    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] high_water;

    modport master (
        output in_valid, in_pc, in_warpId, in_tmask,
        output in_regs_0_enable, in_regs_0_address, in_regs_0_data,
        output in_regs_1_enable, in_regs_1_address, in_regs_1_data,
        output in_regs_2_enable, in_regs_2_address, in_regs_2_data,
        input  in_ready,
        input  inst_valid, inst_pc, inst_warpId, inst_tmask,
        input  inst_regs_0_enable, inst_regs_0_address, inst_regs_0_data,
        input  inst_regs_1_enable, inst_regs_1_address, inst_regs_1_data,
        input  inst_regs_2_enable, inst_regs_2_address, inst_regs_2_data,
        input  occupancy, high_water
    );

    modport slave (
        input  in_valid, in_pc, in_warpId, in_tmask,
        input  in_regs_0_enable, in_regs_0_address, in_regs_0_data,
        input  in_regs_1_enable, in_regs_1_address, in_regs_1_data,
        input  in_regs_2_enable, in_regs_2_address, in_regs_2_data,
        output in_ready,
        output inst_valid, inst_pc, inst_warpId, inst_tmask,
        output inst_regs_0_enable, inst_regs_0_address, inst_regs_0_data,
        output inst_regs_1_enable, inst_regs_1_address, inst_regs_1_data,
        output inst_regs_2_enable, inst_regs_2_address, inst_regs_2_data,
        output occupancy, high_water
    );

endinterface

// File: rtl/trace_retire_serializer_compact.sv
// Prefix popcount over accepted ports: each port's slot offset from
// the FIFO tail, plus the total number enqueued this cycle.
// Ports: valid/accept in; fire, offset, nenq out.
module trace_retire_serializer_compact #(
    parameter int ENQ_PORTS = 2,
    parameter int OFF_W     = $clog2(ENQ_PORTS + 1)
) (
    input  logic [ENQ_PORTS-1:0]            valid,
    input  logic                            accept,
    output logic [ENQ_PORTS-1:0]            fire,
    output logic [ENQ_PORTS-1:0][OFF_W-1:0] offset,
    output logic [OFF_W-1:0]                nenq
);

    logic [OFF_W-1:0] run;

    always_comb begin
        run    = '0;
        fire   = valid & {ENQ_PORTS{accept}};
        offset = '0;
        for (int p = 0; p < ENQ_PORTS; p++) begin
            offset[p] = run;
            run       = run + OFF_W'(fire[p]);
        end
        nenq = run;
    end

endmodule

// File: rtl/trace_retire_serializer.sv
// Serializes up to ENQ_PORTS retired instructions per cycle into a
// one-per-cycle trace stream, in retirement then port order.
// Ports: clock, reset (async, active-high), bus (slave side).
module trace_retire_serializer
    import trace_retire_serializer_pkg::*;
#(
    parameter int ENQ_PORTS = DEF_ENQ_PORTS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    trace_retire_serializer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int OFF_W = cnt_width(ENQ_PORTS);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] hw_q;
    logic             ready_q;
    logic             ready_d;
    logic             deq;

    logic [ENQ_PORTS-1:0]            fire;
    logic [ENQ_PORTS-1:0][OFF_W-1:0] offset;
    logic [OFF_W-1:0]                nenq;

    trace_inst_t      mem [DEPTH];
    trace_inst_t      rec [ENQ_PORTS];
    logic [PTR_W-1:0] slot [ENQ_PORTS];
    trace_inst_t      head_rec;

    trace_retire_serializer_compact #(
        .ENQ_PORTS (ENQ_PORTS),
        .OFF_W     (OFF_W)
    ) u_compact (
        .valid  (bus.in_valid),
        .accept (ready_q),
        .fire   (fire),
        .offset (offset),
        .nenq   (nenq)
    );

    always_comb begin
        for (int p = 0; p < ENQ_PORTS; p++) begin
            rec[p] = '0;
            rec[p].pc =
                bus.in_pc[p*ARCH_LEN +: ARCH_LEN];
            rec[p].warpId =
                bus.in_warpId[p*WARP_ID_BITS +: WARP_ID_BITS];
            rec[p].tmask =
                bus.in_tmask[p*NUM_LANES +: NUM_LANES];
            rec[p].regs[0].enable = bus.in_regs_0_enable[p];
            rec[p].regs[0].address =
                bus.in_regs_0_address[p*REG_BITS +: REG_BITS];
            rec[p].regs[0].data =
                bus.in_regs_0_data[p*LANE_DATA_W +: LANE_DATA_W];
            rec[p].regs[1].enable = bus.in_regs_1_enable[p];
            rec[p].regs[1].address =
                bus.in_regs_1_address[p*REG_BITS +: REG_BITS];
            rec[p].regs[1].data =
                bus.in_regs_1_data[p*LANE_DATA_W +: LANE_DATA_W];
            rec[p].regs[2].enable = bus.in_regs_2_enable[p];
            rec[p].regs[2].address =
                bus.in_regs_2_address[p*REG_BITS +: REG_BITS];
            rec[p].regs[2].data =
                bus.in_regs_2_data[p*LANE_DATA_W +: LANE_DATA_W];
        end
    end

    // Compacted slots wrap naturally with the pointer width.
    always_comb begin
        for (int p = 0; p < ENQ_PORTS; p++) begin
            slot[p] = tail_q + PTR_W'(offset[p]);
        end
    end

    always_comb begin
        deq     = (count_q != '0);
        count_d = count_q + CNT_W'(nenq) - CNT_W'(deq);
        // Ready is judged on the next count so it can be registered;
        // this gives the same value as free(count) in every live cycle
        // while holding in_ready low through reset.
        ready_d = (DEPTH - int'(count_d)) >= ENQ_PORTS;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hw_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_q + PTR_W'(deq);
            tail_q  <= tail_q + PTR_W'(nenq);
            count_q <= count_d;
            ready_q <= ready_d;
            if (count_d > hw_q) begin
                hw_q <= count_d;
            end
        end
    end

    // Payload storage carries no reset; stale entries are never read
    // because count gates the head.
    always_ff @(posedge clock) begin
        for (int p = 0; p < ENQ_PORTS; p++) begin
            if (fire[p]) begin
                mem[slot[p]] <= rec[p];
            end
        end
    end

    always_comb begin
        head_rec = '0;
        if (deq) begin
            head_rec = mem[head_q];
        end
    end

    assign bus.in_ready            = ready_q;
    assign bus.inst_valid          = deq;
    assign bus.inst_pc             = head_rec.pc;
    assign bus.inst_warpId         = head_rec.warpId;
    assign bus.inst_tmask          = head_rec.tmask;
    assign bus.inst_regs_0_enable  = head_rec.regs[0].enable;
    assign bus.inst_regs_0_address = head_rec.regs[0].address;
    assign bus.inst_regs_0_data    = head_rec.regs[0].data;
    assign bus.inst_regs_1_enable  = head_rec.regs[1].enable;
    assign bus.inst_regs_1_address = head_rec.regs[1].address;
    assign bus.inst_regs_1_data    = head_rec.regs[1].data;
    assign bus.inst_regs_2_enable  = head_rec.regs[2].enable;
    assign bus.inst_regs_2_address = head_rec.regs[2].address;
    assign bus.inst_regs_2_data    = head_rec.regs[2].data;
    assign bus.occupancy           = count_q;
    assign bus.high_water          = hw_q;

    no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        int'(count_d) <= DEPTH
    );

    no_enq_when_stalled: assert property (
        @(posedge clock) disable iff (reset)
        ready_q || (nenq == '0)
    );

endmodule
